// File: rtl/pci_pkg.sv
// Shared PCI definitions: command and completion-status codes, master FSM states
// and the latched user request.
package pci_pkg;

  localparam logic [3:0] CMD_IO_RD  = 4'b0010;
  localparam logic [3:0] CMD_IO_WR  = 4'b0011;
  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_MABORT   = 2'b01;
  localparam logic [1:0] ST_TABORT   = 2'b10;
  localparam logic [1:0] ST_RETRY_EX = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_DATA,
    S_TURN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be_n;
  } cmd_t;

  function automatic logic is_write(input logic [3:0] code);
    return code[0];
  endfunction

endpackage

// File: rtl/pci_par_gen.sv
// PCI parity: even parity over the 36 bits of AD and C/BE# registered one clock behind them;
// the parity output enable follows the AD output enable with the same delay.
module pci_par_gen
  import pci_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ad,
  input  logic [3:0]  cbe_n,
  input  logic        oe_ad_n,
  output logic        par,
  output logic        oe_par_n
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par      <= 1'b0;
      oe_par_n <= 1'b1;
    end else begin
      par      <= ^{ad, cbe_n};
      oe_par_n <= oe_ad_n;
    end
  end

endmodule

// File: rtl/pci_master.sv
// Single-data-phase PCI initiator with retry, master-abort and target-abort handling.
// Latency: arbitration wait, 1 ADDR, >=1 DATA, 1 TURN, 1 DONE clock; CMD_READY stays low until back in IDLE.
module pci_master
  import pci_pkg::*;
#(
  parameter int MAX_RETRY      = 4,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [3:0]  CMD_CODE,
  input  logic [31:0] CMD_ADDR,
  input  logic [31:0] CMD_DATA,
  input  logic [3:0]  CMD_BE_N,
  output logic        RSP_VALID,
  output logic [31:0] RSP_DATA,
  output logic [1:0]  RSP_STATUS,
  input  logic [31:0] AD_I,
  output logic [31:0] AD_O,
  output logic        OE_AD_N,
  output logic [3:0]  CBE_O_N,
  output logic        OE_CBE_N,
  output logic        PAR_O,
  output logic        OE_PAR_N,
  input  logic        FRAME_I_N,
  output logic        FRAME_O_N,
  output logic        OE_FRAME_N,
  input  logic        IRDY_I_N,
  output logic        IRDY_O_N,
  output logic        OE_IRDY_N,
  input  logic        TRDY_I_N,
  input  logic        STOP_I_N,
  input  logic        DEVSEL_I_N,
  input  logic        GNT_I_N,
  output logic        REQ_O_N
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int TW = $clog2(DEVSEL_TIMEOUT + 1);

  state_t        state;
  cmd_t          cmd_q;
  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] dev_cnt;
  logic          retry_pend;
  logic [1:0]    term_status;
  logic [31:0]   rd_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      cmd_q       <= '0;
      retry_cnt   <= '0;
      dev_cnt     <= '0;
      retry_pend  <= 1'b0;
      term_status <= ST_OK;
      rd_data     <= '0;
      CMD_READY   <= 1'b0;
      RSP_VALID   <= 1'b0;
      RSP_DATA    <= '0;
      RSP_STATUS  <= ST_OK;
      AD_O        <= '0;
      OE_AD_N     <= 1'b1;
      CBE_O_N     <= 4'hF;
      OE_CBE_N    <= 1'b1;
      FRAME_O_N   <= 1'b1;
      OE_FRAME_N  <= 1'b1;
      IRDY_O_N    <= 1'b1;
      OE_IRDY_N   <= 1'b1;
      REQ_O_N     <= 1'b1;
    end else begin
      RSP_VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          CMD_READY <= 1'b1;
          if (CMD_VALID && CMD_READY) begin
            cmd_q     <= '{code: CMD_CODE, addr: CMD_ADDR, data: CMD_DATA, be_n: CMD_BE_N};
            retry_cnt <= '0;
            rd_data   <= '0;
            CMD_READY <= 1'b0;
            REQ_O_N   <= 1'b0;
            state     <= S_REQ;
          end
        end

        // Start only on a granted, idle bus (no FRAME#, no IRDY# from the previous owner).
        S_REQ: begin
          if (!GNT_I_N && FRAME_I_N && IRDY_I_N) begin
            REQ_O_N    <= 1'b1;
            FRAME_O_N  <= 1'b0;
            IRDY_O_N   <= 1'b1;
            AD_O       <= cmd_q.addr;
            CBE_O_N    <= cmd_q.code;
            OE_AD_N    <= 1'b0;
            OE_CBE_N   <= 1'b0;
            OE_FRAME_N <= 1'b0;
            OE_IRDY_N  <= 1'b0;
            state      <= S_ADDR;
          end
        end

        S_ADDR: begin
          FRAME_O_N <= 1'b1;
          IRDY_O_N  <= 1'b0;
          CBE_O_N   <= cmd_q.be_n;
          dev_cnt   <= '0;
          if (is_write(cmd_q.code)) begin
            AD_O    <= cmd_q.data;
            OE_AD_N <= 1'b0;
          end else begin
            OE_AD_N <= 1'b1;
          end
          state <= S_DATA;
        end

        S_DATA: begin
          if (!DEVSEL_I_N && !TRDY_I_N) begin
            term_status <= ST_OK;
            if (!is_write(cmd_q.code)) rd_data <= AD_I;
            IRDY_O_N <= 1'b1;
            OE_AD_N  <= 1'b1;
            OE_CBE_N <= 1'b1;
            state    <= S_TURN;
          end else if (!DEVSEL_I_N && !STOP_I_N) begin
            if (retry_cnt < RW'(MAX_RETRY)) begin
              retry_cnt  <= retry_cnt + RW'(1);
              retry_pend <= 1'b1;
            end else begin
              term_status <= ST_RETRY_EX;
            end
            IRDY_O_N <= 1'b1;
            OE_AD_N  <= 1'b1;
            OE_CBE_N <= 1'b1;
            state    <= S_TURN;
          end else if (DEVSEL_I_N && !STOP_I_N) begin
            term_status <= ST_TABORT;
            IRDY_O_N    <= 1'b1;
            OE_AD_N     <= 1'b1;
            OE_CBE_N    <= 1'b1;
            state       <= S_TURN;
          end else if (DEVSEL_I_N) begin
            // Nobody claimed the cycle: give up after DEVSEL_TIMEOUT data clocks.
            if (dev_cnt == TW'(DEVSEL_TIMEOUT - 1)) begin
              term_status <= ST_MABORT;
              IRDY_O_N    <= 1'b1;
              OE_AD_N     <= 1'b1;
              OE_CBE_N    <= 1'b1;
              state       <= S_TURN;
            end else begin
              dev_cnt <= dev_cnt + TW'(1);
            end
          end
        end

        S_TURN: begin
          OE_AD_N    <= 1'b1;
          OE_CBE_N   <= 1'b1;
          OE_FRAME_N <= 1'b1;
          OE_IRDY_N  <= 1'b1;
          if (retry_pend) begin
            retry_pend <= 1'b0;
            REQ_O_N    <= 1'b0;
            state      <= S_REQ;
          end else begin
            RSP_VALID  <= 1'b1;
            RSP_DATA   <= rd_data;
            RSP_STATUS <= term_status;
            state      <= S_DONE;
          end
        end

        S_DONE: begin
          CMD_READY <= 1'b1;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  pci_par_gen u_par (
    .CLK      (CLK),
    .RST      (RST),
    .ad       (AD_O),
    .cbe_n    (CBE_O_N),
    .oe_ad_n  (OE_AD_N),
    .par      (PAR_O),
    .oe_par_n (OE_PAR_N)
  );

endmodule

// File: doc/pci_master.md
PCI_MASTER -- requirements
Module: pci_master

Interface
REQ-001 Parameter MAX_RETRY, default 4: retry terminations accepted before giving up.
REQ-002 Parameter DEVSEL_TIMEOUT, default 5: clocks after address phase to wait for DEVSEL# before master abort.
REQ-003 CLK  in  1  PCI clock; all state changes on rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 CMD_VALID  in  1  user request present.
REQ-006 CMD_READY  out  1  block accepts request (high only in IDLE).
REQ-007 CMD_CODE  in  4  PCI command (0010 IO rd, 0011 IO wr, 0110 mem rd, 0111 mem wr); bit0 = write.
REQ-008 CMD_ADDR  in  32  target address.
REQ-009 CMD_DATA  in  32  write data.
REQ-010 CMD_BE_N  in  4  active-low byte enables.
REQ-011 RSP_VALID  out  1  one-cycle pulse, transaction finished.
REQ-012 RSP_DATA  out  32  read data, valid with RSP_VALID.
REQ-013 RSP_STATUS  out  2  00 ok, 01 master abort, 10 target abort, 11 retry exhausted.
REQ-014 AD_I  in  32  bus AD sampled.
REQ-015 AD_O  out  32  bus AD driven.
REQ-016 OE_AD_N  out  1  AD output enable, low = drive.
REQ-017 CBE_O_N  out  4  C/BE# driven.
REQ-018 OE_CBE_N  out  1  C/BE# output enable.
REQ-019 PAR_O  out  1  parity driven.
REQ-020 OE_PAR_N  out  1  PAR output enable.
REQ-021 FRAME_I_N  in  1  FRAME# sampled (bus idle detect).
REQ-022 FRAME_O_N  out  1  FRAME# driven.
REQ-023 OE_FRAME_N  out  1  FRAME# output enable.
REQ-024 IRDY_I_N  in  1  IRDY# sampled (bus idle detect).
REQ-025 IRDY_O_N  out  1  IRDY# driven.
REQ-026 OE_IRDY_N  out  1  IRDY# output enable.
REQ-027 TRDY_I_N, STOP_I_N, DEVSEL_I_N  in  1 each  target responses.
REQ-028 GNT_I_N  in  1  arbiter grant.
REQ-029 REQ_O_N  out  1  bus request to arbiter, always driven.

Function
REQ-030 FSM states IDLE, REQ, ADDR, DATA, TURN, DONE; all outputs registered on rising CLK.
REQ-031 IDLE: CMD_VALID&CMD_READY latches CODE/ADDR/DATA/BE, clears retry count, -> REQ.
REQ-032 REQ: REQ_O_N=0; -> ADDR when GNT_I_N=0 and FRAME_I_N=1 and IRDY_I_N=1 sampled same edge; else wait indefinitely.
REQ-033 ADDR (1 clock): FRAME_O_N=0, AD_O=addr, CBE_O_N=code, OE_AD_N/OE_CBE_N/OE_FRAME_N/OE_IRDY_N=0, IRDY_O_N=1; REQ_O_N=1.
REQ-034 DATA: single data phase only -- FRAME_O_N=1, IRDY_O_N=0, CBE_O_N=BE; write: AD_O=data, OE_AD_N=0; read: OE_AD_N=1 (turnaround).
REQ-035 DATA termination, priority order: DEVSEL_I_N=0&TRDY_I_N=0 -> status 00, read captures AD_I; DEVSEL_I_N=0&STOP_I_N=0&TRDY_I_N=1 -> retry; DEVSEL_I_N=1&STOP_I_N=0 -> status 10; DEVSEL_I_N=1 for DEVSEL_TIMEOUT clocks -> status 01.
REQ-036 Retry: count+1; count<MAX_RETRY -> TURN then REQ; count=MAX_RETRY -> status 11.
REQ-037 TURN (1 clock): IRDY_O_N=1, FRAME_O_N=1 still driven; all OE high next clock.
REQ-038 DONE: RSP_VALID=1 one clock, -> IDLE; RSP_DATA holds until next RSP_VALID.
REQ-039 PAR_O = XOR(AD_O,CBE_O_N) of previous clock; OE_PAR_N = previous-clock OE_AD_N (address and write data only).
REQ-040 GNT_I_N removal after ADDR ignored; DEVSEL count starts in first DATA clock.

Reset
REQ-041 RST asynchronously forces IDLE: all OE_*_N=1, REQ_O_N=1, FRAME_O_N=IRDY_O_N=1, AD_O=0, CBE_O_N=F, PAR_O=0, RSP_VALID=0, RSP_DATA=0, RSP_STATUS=00, CMD_READY=0 until first clock after release; mid-transaction reset releases bus without TURN.

Structure
REQ-042 Shared pci_pkg holds command codes, status codes, FSM state enum.
REQ-043 Parity register as sub-module pci_par_gen (36-bit XOR, 1-clock delay, OE delay).

Verification
REQ-044 IO write 0x0000_0010 data 0xA5A5_5A5A, target DEVSEL+TRDY 1st DATA clock -> AD/CBE 0011 in ADDR, PAR correct, RSP_STATUS=00.
REQ-045 Mem read 0x8000_0000, target returns 0x1234_5678 after 2 wait clocks -> OE_AD_N=1 in DATA, RSP_DATA=0x1234_5678, status 00.
REQ-046 No DEVSEL -> IRDY released after 5 DATA clocks, RSP_STATUS=01.
REQ-047 Target STOP without TRDY 5 times -> 4 re-arbitrations, RSP_STATUS=11; retry succeeding on 3rd attempt -> status 00.
REQ-048 GNT_I_N low but FRAME_I_N low -> no ADDR until FRAME_I_N and IRDY_I_N high; RST during DATA -> all OE high immediately.
